div_result_bcd: RTL and testbench
=================================

// Module: div_result_bcd
// PURPOSE
//  Sequential binary-to-BCD converter downstream of the 32-bit unsigned divider.
//  Captures the divider's quotient and remainder on a start pulse.
//  Converts both with shift-add-3 (double dabble), one bit per clock: quotient first, then remainder.
//  Presents two packed BCD words for the display/readout stage.
// PARAMETERS
//  WIDTH   32  binary operand width (quotient and remainder)
//  DIGITS  10  BCD digits per result; must satisfy 10^DIGITS > 2^WIDTH
// PORTS
//  clk        in   1           rising-edge clock, sole clock
//  reset      in   1           synchronous, active-high
//  start      in   1           request conversion of quotient_in/remainder_in
//  quotient_in  in WIDTH       binary quotient from divider
//  remainder_in in WIDTH       binary remainder from divider
//  busy       out  1           high while converting
//  done       out  1           one-cycle pulse: q_bcd/r_bcd just updated
//  q_bcd      out  4*DIGITS    quotient BCD, digit 0 (units) in [3:0]
//  r_bcd      out  4*DIGITS    remainder BCD, same packing
// BEHAVIOUR
//  Interface: one clock clk; reset is synchronous and active-high.
//  Reset (any state, incl. mid-conversion)
//   - State -> IDLE; busy=0, done=0, q_bcd=0, r_bcd=0.
//   - Internal shift/BCD registers cleared; in-flight conversion discarded, no done.
//  States: IDLE, CONV_Q, CONV_R, FINISH.
//  IDLE
//   - start=1 latches quotient_in and remainder_in into shift registers.
//   - Clears BCD accumulator, sets bit counter=WIDTH-1 -> CONV_Q; busy=1 from next cycle.
//  CONV_Q / CONV_R step, one per clock
//   - Every digit >=5 gets +3 (all digits in parallel, combinational).
//   - Then {bcd,shift} shifts left 1; the MSB of the binary register enters BCD digit 0 bit 0.
//  Counter handling
//   - Counter decrements each step; after the step at counter=0:
//   - CONV_Q -> stores the accumulator to an internal q hold, reloads the counter, clears the accumulator -> CONV_R.
//   - CONV_R -> FINISH.
//  FINISH (1 cycle)
//   - q_bcd<=q hold and r_bcd<=accumulator simultaneously; done=1, busy=0.
//   - -> IDLE.
//  Latency: start sampled at edge N; done high in the cycle after edge N+2*WIDTH+1.
//   - Default WIDTH: 65 clocks.
//  q_bcd/r_bcd hold the previous result until FINISH; never show partial values.
//  start while busy (CONV_Q/CONV_R/FINISH): ignored, not queued; operands are not re-sampled.
//  start in the cycle after done (back in IDLE): accepted normally.
//   - Back-to-back throughput: one result per 2*WIDTH+2 clocks.
//  Width rule: add-3 operates on 4-bit digits, no carry between digits.
//   - The top digit never exceeds 4 before the add-3 for WIDTH=32, DIGITS=10.
//  Divide-by-zero results from the divider are converted literally; no special case.
// STRUCTURE
//  Shared package div_pkg:
//   - constants DIV_WIDTH=32, BCD_DIGITS=10.
//   - state encoding localparams for IDLE/CONV_Q/CONV_R/FINISH.
//  Sub-module bcd_add3_digit: combinational 4-bit in -> (in>=5 ? in+3 : in); DIGITS instances.
//  Top: FSM, bit counter ($clog2(WIDTH) bits), WIDTH-bit shift reg, 4*DIGITS accumulator + q hold.
// TESTING
//  1 q=0, r=0, start -> done after 65 clks; q_bcd=0, r_bcd=0; busy high exactly 64 clks.
//  2 q=1234567890, r=42 -> q_bcd=40'h1234567890, r_bcd=40'h0000000042.
//  3 q=32'hFFFFFFFF, r=32'h0000FFFF -> q_bcd=40'h4294967295, r_bcd=40'h0000065535.
//  4 start pulse at clk 10 of conversion (q=7) -> ignored; result of first operands only, one done.
//  5 start in cycle after done with q=99,r=5 -> second done 65 clks later; q_bcd=...099, r_bcd=...005.
//  6 reset at clk 30 of conversion -> outputs 0, no done; new start afterwards converts correctly.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and FSM encoding for the divider result path
package div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int BCD_DIGITS = 10;

    localparam logic [1:0] ENC_IDLE   = 2'd0;
    localparam logic [1:0] ENC_CONV_Q = 2'd1;
    localparam logic [1:0] ENC_CONV_R = 2'd2;
    localparam logic [1:0] ENC_FINISH = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ENC_IDLE,
        CONV_Q = ENC_CONV_Q,
        CONV_R = ENC_CONV_R,
        FINISH = ENC_FINISH
    } conv_state_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// rtl/bcd_add3_digit.sv - double-dabble digit correction (add 3 when digit >= 5)
module bcd_add3_digit (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Digits 5..9 become 8..12 so the following left shift carries into the next digit
    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/div_result_bcd.sv
// rtl/div_result_bcd.sv - sequential binary-to-BCD converter for divider quotient and remainder
module div_result_bcd
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int DIGITS = BCD_DIGITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    quotient_in,
    input  logic [WIDTH-1:0]    remainder_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] q_bcd,
    output logic [4*DIGITS-1:0] r_bcd
);

    localparam int CW = $clog2(WIDTH);
    localparam int BW = 4 * DIGITS;
    localparam int SW = 2 * WIDTH;

    conv_state_t   state;
    conv_state_t   state_next;
    logic [CW-1:0] count;
    // Quotient in the upper half, remainder in the lower half: after WIDTH shifts
    // the remainder has moved up to the MSB end, ready for the second pass.
    logic [SW-1:0] shift;
    logic [BW-1:0] acc;
    logic [BW-1:0] q_hold;
    logic [BW-1:0] acc_adj;
    logic [BW-1:0] acc_step;

    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit    (acc[4*d +: 4]),
            .adjusted (acc_adj[4*d +: 4])
        );
    end

    assign acc_step = {acc_adj[BW-2:0], shift[SW-1]};
    assign busy     = (state == CONV_Q) || (state == CONV_R);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each conversion pass ends after the step at count zero
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CONV_Q;
            CONV_Q:  if (count == '0) state_next = CONV_R;
            CONV_R:  if (count == '0) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add-3 steps, result publication
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            shift  <= '0;
            acc    <= '0;
            q_hold <= '0;
            q_bcd  <= '0;
            r_bcd  <= '0;
            done   <= 1'b0;
        end else begin
            done <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (start) begin
                        shift <= {quotient_in, remainder_in};
                        acc   <= '0;
                        count <= CW'(WIDTH - 1);
                    end
                end
                CONV_Q: begin
                    shift <= {shift[SW-2:0], 1'b0};
                    if (count == '0) begin
                        q_hold <= acc_step;
                        acc    <= '0;
                        count  <= CW'(WIDTH - 1);
                    end else begin
                        acc   <= acc_step;
                        count <= count - 1'b1;
                    end
                end
                CONV_R: begin
                    shift <= {shift[SW-2:0], 1'b0};
                    acc   <= acc_step;
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end
                end
                FINISH: begin
                    q_bcd <= q_hold;
                    r_bcd <= acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// tb/tb_div_result_bcd.sv - scoreboard bench for div_result_bcd
module tb_div_result_bcd;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] quotient_in;
    logic [31:0] remainder_in;
    logic        busy;
    logic        done;
    logic [39:0] q_bcd;
    logic [39:0] r_bcd;

    typedef struct {
        logic [39:0] q;
        logic [39:0] r;
    } exp_t;

    exp_t expq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    div_result_bcd dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .quotient_in  (quotient_in),
        .remainder_in (remainder_in),
        .busy         (busy),
        .done         (done),
        .q_bcd        (q_bcd),
        .r_bcd        (r_bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] to_bcd(input logic [31:0] v);
        logic [39:0] res;
        logic [31:0] x;
        res = '0;
        x   = v;
        for (int i = 0; i < 10; i++) begin
            res[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive start at a negedge; the following posedge samples it
    task automatic issue(input logic [31:0] q, input logic [31:0] r, input logic [39:0] eq,
                         input logic [39:0] er);
        exp_t e;
        @(negedge clk);
        quotient_in  = q;
        remainder_in = r;
        start        = 1'b1;
        e.q = eq;
        e.r = er;
        expq.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for done after a start edge; optional stray start injected at cycle inject_at
    task automatic wait_done(input string tag, input int inject_at);
        int   cycles;
        int   busy_cycles;
        bit   seen;
        exp_t e;
        cycles      = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        while (!seen && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (cycles == inject_at) begin
                quotient_in  = 32'd7;
                remainder_in = 32'd3;
                start        = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_latency"}, 64'(cycles - 1), 64'd65);
            check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd64);
            check({tag, "_queue_nonempty"}, 64'(expq.size() > 0), 64'd1);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check({tag, "_q_bcd"}, 64'(q_bcd), 64'(e.q));
                check({tag, "_r_bcd"}, 64'(r_bcd), 64'(e.r));
            end
        end
    endtask

    task automatic count_stray_dones(input string tag, input int n);
        int dones;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check({tag, "_no_extra_done"}, 64'(dones), 64'd0);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        quotient_in  = '0;
        remainder_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_q_bcd", 64'(q_bcd), 64'd0);
        check("reset_r_bcd", 64'(r_bcd), 64'd0);
        reset = 1'b0;

        // 1: zeros
        issue(32'd0, 32'd0, 40'h0, 40'h0);
        wait_done("zero", 0);
        @(negedge clk);
        check("done_one_pulse", 64'(done), 64'd0);

        // 2: mixed digits
        issue(32'd1234567890, 32'd42, 40'h1234567890, 40'h0000000042);
        wait_done("mixed", 0);

        // 3: maximum quotient
        issue(32'hFFFFFFFF, 32'h0000FFFF, 40'h4294967295, 40'h0000065535);
        wait_done("max", 0);

        // 4: stray start at clk 10 of conversion must be ignored
        issue(32'd7, 32'd0, to_bcd(32'd7), to_bcd(32'd0));
        wait_done("ignore_start", 10);
        count_stray_dones("ignore_start", 70);

        // 5: start in the cycle right after done
        issue(32'd13579, 32'd2468, to_bcd(32'd13579), to_bcd(32'd2468));
        wait_done("b2b_first", 0);
        issue(32'd99, 32'd5, 40'h0000000099, 40'h0000000005);
        wait_done("b2b_second", 0);

        // 6: reset at clk 30 of a conversion
        @(negedge clk);
        quotient_in  = 32'd55555;
        remainder_in = 32'd77;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_q_bcd", 64'(q_bcd), 64'd0);
        check("midreset_r_bcd", 64'(r_bcd), 64'd0);
        count_stray_dones("midreset", 80);
        issue(32'd65536, 32'd999, to_bcd(32'd65536), to_bcd(32'd999));
        wait_done("after_reset", 0);

        check("scoreboard_empty", 64'(expq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
